// File: rtl/pan_pkg.sv
// Shared types and helpers for the streaming PAN checker.
package pan_pkg;

  localparam int LEN_W = 5;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    SHORT    = 2'd1,
    OVERFLOW = 2'd2,
    BADDIGIT = 2'd3
  } pan_err_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } pan_state_e;

  // Luhn doubling with the digit-sum folded in: 2d for d<5, else 2d-9.
  function automatic logic [3:0] luhn_dbl(input logic [3:0] d);
    logic [4:0] t;
    t = {d, 1'b0};
    if (d < 4'd5) return t[3:0];
    else          return 4'(t - 5'd9);
  endfunction

endpackage

// File: rtl/luhn_dual_acc.sv
// Two mod-10 Luhn accumulators, one per possible final-length parity, so the
// check can be resolved at frame end without buffering the PAN.
module luhn_dual_acc
  import pan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] digit,
  input  logic       len_odd,
  output logic       sum_zero
);

  logic [3:0] acc_e;
  logic [3:0] acc_o;
  logic       pos_even;  // next digit lands on an even 1-based position
  logic [3:0] d_dbl;
  logic [3:0] add_e;
  logic [3:0] add_o;

  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  // acc_e assumes an even final length (odd positions doubled), acc_o the reverse.
  always_comb begin
    d_dbl = luhn_dbl(digit);
    add_e = pos_even ? digit : d_dbl;
    add_o = pos_even ? d_dbl : digit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_e    <= '0;
      acc_o    <= '0;
      pos_even <= 1'b0;
    end else if (clr) begin
      acc_e    <= '0;
      acc_o    <= '0;
      pos_even <= 1'b0;
    end else if (en) begin
      acc_e    <= add_mod10(acc_e, add_e);
      acc_o    <= add_mod10(acc_o, add_o);
      pos_even <= ~pos_even;
    end
  end

  assign sum_zero = len_odd ? (acc_o == 4'd0) : (acc_e == 4'd0);

endmodule

// File: rtl/pan_luhn_stream.sv
// Streaming PAN checker: Luhn, length/digit classification and IIN capture,
// result on a valid/ready port. Optional last-four capture: PAN_LAST4_EN.
module pan_luhn_stream
  import pan_pkg::*;
#(
  parameter int MIN_LEN       = 12,
  parameter int MAX_LEN       = 19,
  parameter int PREFIX_DIGITS = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         digit_valid,
  input  logic [3:0]                   digit_in,
  input  logic                         pan_end,
  output logic                         busy,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         luhn_ok,
  output logic [LEN_W-1:0]             len_out,
  output logic [1:0]                   err_code,
  output logic [4*PREFIX_DIGITS-1:0]   prefix_bcd,
  output logic [15:0]                  last4_bcd,
  output pan_state_e                   state_dbg
);

  // Handshake: result_valid rises one cycle after the FSM reaches DONE and
  // stays high, with every field frozen, until result_valid && result_ready
  // at a rising edge; start at any time drops the result without handshake.

  // With MAX_LEN=31 the saturated length cannot exceed the 5-bit field.
  localparam logic [LEN_W-1:0] LEN_CAP = (MAX_LEN >= 31) ? LEN_W'(31) : LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);

  pan_state_e                 state_q;
  pan_state_e                 state_d;
  logic [LEN_W-1:0]           len_q;
  logic [4*PREFIX_DIGITS-1:0] prefix_q;
  logic                       bad_q;
  logic                       ovf_q;
  logic                       res_valid_q;
  logic                       luhn_ok_q;
  logic [LEN_W-1:0]           len_out_q;
  pan_err_e                   err_out_q;
  logic [4*PREFIX_DIGITS-1:0] prefix_out_q;

  logic     take_digit;
  logic     in_range;
  logic     acc_en;
  logic     handshake;
  logic     load_result;
  logic     sum_zero;
  pan_err_e err_final;

  assign take_digit  = (state_q == COLLECT) && digit_valid && !start;
  assign in_range    = (len_q < MAX_L);
  assign acc_en      = take_digit && in_range && (digit_in <= 4'd9);
  assign handshake   = res_valid_q && result_ready;
  assign load_result = (state_q == DONE) && !res_valid_q && !start;

  luhn_dual_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .en       (acc_en),
    .digit    (digit_in),
    .len_odd  (len_q[0]),
    .sum_zero (sum_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (pan_end)   state_d = DONE;
        DONE:    if (handshake) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    err_final = NONE;
    if (bad_q)              err_final = BADDIGIT;
    else if (ovf_q)         err_final = OVERFLOW;
    else if (len_q < MIN_L) err_final = SHORT;
  end

  // Frame accumulation; digits beyond MAX_LEN only count toward the length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      prefix_q <= '0;
      bad_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (start) begin
      len_q    <= '0;
      prefix_q <= '0;
      bad_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (take_digit) begin
      if (in_range) begin
        len_q <= len_q + 1'b1;
        if (digit_in > 4'd9) bad_q <= 1'b1;
        for (int i = 0; i < PREFIX_DIGITS; i++) begin
          if (len_q == LEN_W'(i)) prefix_q[4*(PREFIX_DIGITS-1-i) +: 4] <= digit_in;
        end
      end else begin
        ovf_q <= 1'b1;
        len_q <= LEN_CAP;
      end
    end
  end

  // Result registers load the cycle after DONE is entered, once the final digit has settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      luhn_ok_q    <= 1'b0;
      len_out_q    <= '0;
      err_out_q    <= NONE;
      prefix_out_q <= '0;
    end else if (start || handshake) begin
      res_valid_q  <= 1'b0;
      luhn_ok_q    <= 1'b0;
      len_out_q    <= '0;
      err_out_q    <= NONE;
      prefix_out_q <= '0;
    end else if (load_result) begin
      res_valid_q  <= 1'b1;
      luhn_ok_q    <= (err_final == NONE) && sum_zero;
      len_out_q    <= len_q;
      err_out_q    <= err_final;
      prefix_out_q <= prefix_q;
    end
  end

`ifdef PAN_LAST4_EN
  logic [15:0] last4_q;
  logic [15:0] last4_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last4_q     <= '0;
      last4_out_q <= '0;
    end else begin
      if (start)                        last4_q <= '0;
      else if (take_digit && in_range)  last4_q <= {last4_q[11:0], digit_in};
      if (start || handshake)           last4_out_q <= '0;
      else if (load_result)             last4_out_q <= last4_q;
    end
  end

  assign last4_bcd = last4_out_q;
`else
  assign last4_bcd = 16'h0000;
`endif

  assign busy         = (state_q == COLLECT);
  assign result_valid = res_valid_q;
  assign luhn_ok      = luhn_ok_q;
  assign len_out      = len_out_q;
  assign err_code     = err_out_q;
  assign prefix_bcd   = prefix_out_q;
  assign state_dbg    = state_q;

endmodule
